// File: rtl/sram_line_pkg.sv
// Shared constants and types for the SRAM line bridge.
//   WORDS      words per cache line
//   WORD_W     SRAM word width
//   DM_W       byte enables per SRAM word
//   LINE_W     full line width (WORDS*WORD_W)
//   DM_LINE_W  full line byte-enable width (WORDS*DM_W)
package sram_line_pkg;
  localparam int WORDS     = 16;
  localparam int WORD_W    = 48;
  localparam int DM_W      = 6;
  localparam int LINE_W    = WORDS * WORD_W;
  localparam int DM_LINE_W = WORDS * DM_W;
  localparam int IDX_W     = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;
endpackage

// File: rtl/sram_word_sel.sv
// Active-word selector (combinational).
//   i_mask  one bit per word that needs an SRAM access
//   i_idx   reference word index
//   i_incl  1: i_idx itself is a candidate (first-word search from 0)
//           0: only words strictly above i_idx (next-word search)
//   o_idx   lowest active word satisfying the above (0 if none)
//   o_last  no active word lies strictly above i_idx
module sram_word_sel #(
  parameter int WORDS = 16,
  parameter int IDX_W = 4
) (
  input  logic [WORDS-1:0] i_mask,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_incl,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);
  always_comb begin
    o_idx  = '0;
    o_last = 1'b1;
    // Scan high to low so the last hit written is the lowest candidate.
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (i_mask[i] && (i > int'(i_idx) || (i_incl && i == int'(i_idx))))
        o_idx = IDX_W'(i);
      if (i_mask[i] && i > int'(i_idx))
        o_last = 1'b0;
    end
  end
endmodule

// File: rtl/sram_line_bridge.sv
// Bridges a full-line read/write request onto a word-wide SRAM port.
// Only words with at least one byte enable are written; reads fetch
// every word. The SRAM may stall any word with sramNak.
//   clk, rst_n         clock, async active-low reset
//   ws_addr/din/dm     line request (addr[5:0] ignored)
//   ws_stb, ws_we      request strobe (IDLE only), 1 = write
//   ws_ack, ws_dout    one-cycle completion pulse, read line
//   sramAddr/InData/Dm word request to SRAM (Dm all-zero = read)
//   sramStb, sramNak   word strobe, controller busy
//   sramOutData        read word, valid in the completing cycle
module sram_line_bridge
  import sram_line_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ws_addr,
  input  logic [LINE_W-1:0]    ws_din,
  input  logic [DM_LINE_W-1:0] ws_dm,
  input  logic                 ws_stb,
  input  logic                 ws_we,
  output logic                 ws_ack,
  output logic [LINE_W-1:0]    ws_dout,
  output logic [31:0]          sramAddr,
  output logic [WORD_W-1:0]    sramInData,
  output logic [DM_W-1:0]      sramDm,
  output logic                 sramStb,
  input  logic                 sramNak,
  input  logic [WORD_W-1:0]    sramOutData
);
  state_e                          r_state;
  logic [25:0]                     r_line;
  logic                            r_we;
  logic [WORDS-1:0]                r_mask;
  logic [IDX_W-1:0]                r_idx;
  logic [WORDS-1:0][WORD_W-1:0]    r_din;
  logic [WORDS-1:0][DM_W-1:0]      r_dm;
  logic [WORDS-1:0][WORD_W-1:0]    r_dout;

  logic [WORDS-1:0][WORD_W-1:0]    w_din_v;
  logic [WORDS-1:0][DM_W-1:0]      w_dm_v;
  logic [WORDS-1:0]                w_in_mask;
  logic [WORDS-1:0]                w_sel_mask;
  logic [IDX_W-1:0]                w_sel_idx;
  logic                            w_sel_incl;
  logic [IDX_W-1:0]                w_nxt;
  logic                            w_last;
  logic                            w_unused;

  assign w_din_v  = ws_din;
  assign w_dm_v   = ws_dm;
  assign ws_dout  = r_dout;
  // Byte offset within the line never reaches the SRAM.
  assign w_unused = ^ws_addr[5:0];

  for (genvar g = 0; g < WORDS; g++) begin : g_mask
    assign w_in_mask[g] = ws_we ? |w_dm_v[g] : 1'b1;
  end

  // One selector serves both searches: in IDLE it finds the first word of
  // the incoming request, in ACCESS the successor of the current word.
  assign w_sel_incl = (r_state == ST_IDLE);
  assign w_sel_mask = w_sel_incl ? w_in_mask : r_mask;
  assign w_sel_idx  = w_sel_incl ? '0 : r_idx;

  sram_word_sel #(.WORDS(WORDS), .IDX_W(IDX_W)) u_sel (
    .i_mask (w_sel_mask),
    .i_idx  (w_sel_idx),
    .i_incl (w_sel_incl),
    .o_idx  (w_nxt),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_line     <= '0;
      r_we       <= 1'b0;
      r_mask     <= '0;
      r_idx      <= '0;
      r_din      <= '0;
      r_dm       <= '0;
      r_dout     <= '0;
      ws_ack     <= 1'b0;
      sramAddr   <= '0;
      sramInData <= '0;
      sramDm     <= '0;
      sramStb    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          ws_ack <= 1'b0;
          if (ws_stb) begin
            r_line <= ws_addr[31:6];
            r_we   <= ws_we;
            r_mask <= w_in_mask;
            r_din  <= w_din_v;
            r_dm   <= w_dm_v;
            if (|w_in_mask) begin
              r_state    <= ST_ACCESS;
              r_idx      <= w_nxt;
              sramStb    <= 1'b1;
              sramAddr   <= {ws_addr[31:6], w_nxt, 2'b00};
              sramInData <= w_din_v[w_nxt];
              sramDm     <= ws_we ? w_dm_v[w_nxt] : '0;
            end else begin
              // Write with no enabled bytes: complete without SRAM traffic.
              r_state <= ST_ACK;
              r_idx   <= '0;
              ws_ack  <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          // While nak'd, nothing changes so the SRAM sees a stable request.
          if (!sramNak) begin
            if (!r_we)
              r_dout[r_idx] <= sramOutData;
            if (w_last) begin
              r_state <= ST_ACK;
              ws_ack  <= 1'b1;
              sramStb <= 1'b0;
              sramDm  <= '0;
            end else begin
              r_idx      <= w_nxt;
              sramAddr   <= {r_line, w_nxt, 2'b00};
              sramInData <= r_din[w_nxt];
              sramDm     <= r_we ? r_dm[w_nxt] : '0;
            end
          end
        end
        ST_ACK: begin
          ws_ack  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          ws_ack  <= 1'b0;
          sramStb <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_line_bridge.sv
// Scoreboard bench for sram_line_bridge: stimulus pushes expected SRAM
// accesses and the expected ack (cycle + line) into queues; a monitor on
// the falling edge pops and compares as the DUT presents them.
module tb_sram_line_bridge;
  import sram_line_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [31:0]          ws_addr = '0;
  logic [LINE_W-1:0]    ws_din = '0;
  logic [DM_LINE_W-1:0] ws_dm = '0;
  logic                 ws_stb = 1'b0;
  logic                 ws_we = 1'b0;
  logic                 ws_ack;
  logic [LINE_W-1:0]    ws_dout;
  logic [31:0]          sramAddr;
  logic [WORD_W-1:0]    sramInData;
  logic [DM_W-1:0]      sramDm;
  logic                 sramStb;
  logic                 sramNak = 1'b0;
  logic [WORD_W-1:0]    sramOutData;

  localparam logic [47:0] RD_C = 48'h000112345678;
  logic rd_mode = 1'b0;
  // SRAM model: constant word, or a word tagged with its own address.
  assign sramOutData = rd_mode ? {16'hA5A5, sramAddr} : RD_C;

  sram_line_bridge dut (
    .clk(clk), .rst_n(rst_n), .ws_addr(ws_addr), .ws_din(ws_din),
    .ws_dm(ws_dm), .ws_stb(ws_stb), .ws_we(ws_we), .ws_ack(ws_ack),
    .ws_dout(ws_dout), .sramAddr(sramAddr), .sramInData(sramInData),
    .sramDm(sramDm), .sramStb(sramStb), .sramNak(sramNak),
    .sramOutData(sramOutData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  dm;
    logic [47:0] data;
    logic        chk_data;
  } acc_t;
  typedef struct {
    int           cyc;
    logic [767:0] dout;
  } ack_t;

  acc_t acc_q[$];
  ack_t ack_q[$];
  int total = 0;
  int bad = 0;
  logic [767:0] exp_dout = '0;

  task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (sramStb) begin
        if (acc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_access act=%h exp=none", sramAddr);
        end else begin
          chk("acc_addr", 768'(sramAddr), 768'(acc_q[0].addr));
          chk("acc_dm", 768'(sramDm), 768'(acc_q[0].dm));
          if (acc_q[0].chk_data)
            chk("acc_data", 768'(sramInData), 768'(acc_q[0].data));
          if (!sramNak) acc_q.delete(0);
        end
      end
      if (ws_ack) begin
        if (ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_ack act=1 exp=0 cyc=%0d", cyc);
        end else begin
          chk("ack_cycle", 768'(cyc), 768'(ack_q[0].cyc));
          chk("ws_dout", ws_dout, ack_q[0].dout);
          ack_q.delete(0);
        end
      end
    end
  end

  // Issue a line request at a falling edge; pushes expected traffic.
  task automatic issue(input logic [31:0] a, input logic we, input logic [767:0] din,
                       input logic [95:0] dm, input int extra);
    int n;
    acc_t e;
    ack_t k;
    logic [31:0] base;
    n = 0;
    base = {a[31:6], 6'b0};
    for (int i = 0; i < 16; i++) begin
      if (!we || dm[i*6 +: 6] != 6'h0) begin
        e.addr = base + 32'(i * 4);
        e.dm = we ? dm[i*6 +: 6] : 6'h0;
        e.data = din[i*48 +: 48];
        e.chk_data = we;
        acc_q.push_back(e);
        n++;
        if (!we) exp_dout[i*48 +: 48] = rd_mode ? {16'hA5A5, e.addr} : RD_C;
      end
    end
    k.cyc = cyc + n + 1 + extra;
    k.dout = exp_dout;
    ack_q.push_back(k);
    ws_addr = a; ws_we = we; ws_din = din; ws_dm = dm; ws_stb = 1'b1;
    @(negedge clk);
    ws_stb = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (ack_q.size() == 0 && acc_q.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok == 0) begin
      total++; bad++;
      $display("FAIL timeout_%s act=pending exp=done", nm);
      acc_q.delete(); ack_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  logic [767:0] din_all;
  logic [95:0]  dm_sparse;
  int found;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) din_all[i*48 +: 48] = 48'h000087654321 + 48'(i);
    dm_sparse = '0;
    dm_sparse[5:0] = 6'h3F;
    dm_sparse[23:18] = 6'h0F;

    // Reset state
    @(negedge clk);
    chk("rst_stb", 768'(sramStb), 768'(0));
    chk("rst_dm", 768'(sramDm), 768'(0));
    chk("rst_addr", 768'(sramAddr), 768'(0));
    chk("rst_indata", 768'(sramInData), 768'(0));
    chk("rst_ack", 768'(ws_ack), 768'(0));
    chk("rst_dout", ws_dout, 768'(0));

    // Full read issued in the first cycle after reset release
    rst_n = 1'b1;
    issue(32'h003FFFC0, 1'b0, '0, '0, 0);
    wait_done("read_const");

    // Full write; dout must keep the previous read line
    issue(32'h003FFFC0, 1'b1, din_all, '1, 0);
    wait_done("write_all");

    // Sparse write: words 0 and 3 only
    issue(32'h003FFFC0, 1'b1, din_all, dm_sparse, 0);
    wait_done("write_sparse");

    // Write with no enables: no SRAM traffic, ack next cycle
    issue(32'h003FFFC0, 1'b1, din_all, '0, 0);
    wait_done("write_none");

    // Read with 3 nak cycles on word 5, low address bits set, ws_stb mid-line
    rd_mode = 1'b1;
    issue(32'h003FFFE7, 1'b0, '0, '0, 3);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (sramStb && sramAddr == 32'h003FFFD4) begin found = 1; break; end
    end
    chk("nak_word5_seen", 768'(found), 768'(1));
    sramNak = 1'b1;
    @(posedge clk); #1;
    ws_addr = 32'h00001000; ws_we = 1'b1; ws_dm = '1; ws_stb = 1'b1;
    @(posedge clk); #1;
    ws_stb = 1'b0;
    @(posedge clk); #1;
    sramNak = 1'b0;
    wait_done("read_nak");

    // Reset during word 7 of a read
    rd_mode = 1'b0;
    @(negedge clk);
    issue(32'h003FFFC0, 1'b0, '0, '0, 0);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (sramStb && sramAddr == 32'h003FFFDC) begin found = 1; break; end
    end
    chk("rst_word7_seen", 768'(found), 768'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_stb", 768'(sramStb), 768'(0));
    chk("midrst_dm", 768'(sramDm), 768'(0));
    chk("midrst_addr", 768'(sramAddr), 768'(0));
    chk("midrst_indata", 768'(sramInData), 768'(0));
    chk("midrst_ack", 768'(ws_ack), 768'(0));
    chk("midrst_dout", ws_dout, 768'(0));
    acc_q.delete(); ack_q.delete();
    exp_dout = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h003FFFC0, 1'b0, '0, '0, 0);
    wait_done("read_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
